// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the fetch and load/store ports onto one synchronous memory.
// Sequences read latency and does read-modify-write for byte/halfword stores.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StRdWait, StWr, StRmwRd, StRmwWr, StDone} state_e;

    localparam logic [2:0] LatLast = 3'(READ_LAT);

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              own_d_q, own_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] rmw_q, rmw_d;
    logic              d_err_q, d_err_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              pick_d;
    logic              misaligned;
    logic [DATA_W-1:0] merged;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        own_d_d    = own_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        rmw_d      = rmw_q;
        d_err_d    = d_err_q;
        if_gnt_d   = 1'b0;
        d_gnt_d    = 1'b0;
        // Fetch wins a tie unless it was the last port served.
        pick_d     = d_req && (!if_req || !last_d_q);
        misaligned = (d_size == 2'b01) ? d_addr[0] :
                     (d_size == 2'b10) ? 1'b0 : (d_addr[1:0] != 2'b00);

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    own_d_d  = pick_d;
                    last_d_d = pick_d;
                    cnt_d    = 3'd0;
                    if (pick_d) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        size_d  = d_size;
                        wdata_d = d_wdata;
                        d_gnt_d = 1'b1;
                        if (misaligned) begin
                            state_d = StDone;
                            d_err_d = 1'b1;
                        end else if (!d_we) begin
                            state_d = StRdWait;
                        end else if (d_size == 2'b01 || d_size == 2'b10) begin
                            state_d = StRmwRd;
                        end else begin
                            state_d = StWr;
                        end
                    end else begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        size_d   = 2'b00;
                        if_gnt_d = 1'b1;
                        state_d  = StRdWait;
                    end
                end
            end
            StRdWait, StRmwRd: begin
                if (cnt_q == LatLast) begin
                    if (state_q == StRmwRd) begin
                        rmw_d   = mem_rdata;
                        state_d = StRmwWr;
                    end else begin
                        if (own_d_q) d_rdata_d = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWr, StRmwWr: state_d = StDone;
            StDone:        state_d = StIdle;
            default:       state_d = StIdle;
        endcase

        if (state_q != StIdle && state_q != StDone && state_d == StDone && own_d_q) begin
            d_err_d = 1'b0;
        end
    end

    always_comb begin
        merged = rmw_q;
        if (size_q == 2'b10) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        mem_wr    = (state_q == StWr) || (state_q == StRmwWr);
        mem_wdata = (state_q == StWr) ? wdata_q : (state_q == StRmwWr) ? merged : '0;
        mem_addr  = (state_q == StIdle) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
        if_done   = (state_q == StDone) && !own_d_q;
        d_done    = (state_q == StDone) && own_d_q;
        busy      = (state_q != StIdle);
        if_gnt    = if_gnt_q;
        d_gnt     = d_gnt_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        d_err     = d_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_d_q   <= 1'b1;
            own_d_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            wdata_q    <= '0;
            cnt_q      <= 3'd0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            rmw_q      <= '0;
            d_err_q    <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            own_d_q    <= own_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            rmw_q      <= rmw_d;
            d_err_q    <= d_err_d;
            if_gnt_q   <= if_gnt_d;
            d_gnt_q    <= d_gnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A at READ_LAT=2, instance B at READ_LAT=1,
// each with a small synchronous memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Backdoor write port shared by both memory models.
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = '0, bd_data = '0;

    // Instance A signals
    logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
    logic [1:0]  a_d_size = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic        a_if_gnt, a_if_done, a_d_gnt, a_d_done, a_d_err, a_mem_wr, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    // Instance B signals
    logic        b_if_req = 0, b_d_req = 0;
    logic [31:0] b_if_addr = 0, b_d_addr = 0;
    logic        b_if_gnt, b_if_done, b_d_gnt, b_d_done, b_d_err, b_mem_wr, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) u_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_done(a_if_done),
        .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_size(a_d_size), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
        .d_err(a_d_err), .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done),
        .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(1'b0), .d_size(2'b00), .d_addr(b_d_addr),
        .d_wdata(32'h0), .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
        .d_err(b_d_err), .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models: rdata reflects the address presented READ_LAT cycles earlier.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] a_p0, a_p1, b_p0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem_a[bd_addr[9:2]] <= bd_data;
            mem_b[bd_addr[9:2]] <= bd_data;
        end else begin
            if (a_mem_wr) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
            if (b_mem_wr) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
        end
        a_p0 <= a_mem_addr;
        a_p1 <= a_p0;
        b_p0 <= b_mem_addr;
    end
    assign a_mem_rdata = mem_a[a_p1[9:2]];
    assign b_mem_rdata = mem_b[b_p0[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        bd_we = 1'b1; bd_addr = addr; bd_data = data;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        logic exp_d;
        int   i;

        tick();
        poke(32'h40, 32'hDEADBEEF);
        poke(32'h100, 32'h11223344);
        poke(32'h8, 32'hCAFEF00D);
        poke(32'h200, 32'h55667788);
        poke(32'h300, 32'h0);

        chk("rst_busy", a_busy, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_mem_wr", a_mem_wr, 0);
        chk("rst_if_rdata", a_if_rdata, 0);
        chk("rst_d_rdata", a_d_rdata, 0);
        chk("rst_d_err", a_d_err, 0);
        chk("rst_pulses", {a_if_gnt, a_d_gnt, a_if_done, a_d_done}, 0);

        // Contention straight out of reset: IF, D, IF, D.
        a_if_addr = 32'h40; a_d_addr = 32'h8; a_d_we = 0; a_d_size = 2'b00;
        a_if_req = 1; a_d_req = 1; reset = 0;
        exp_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (i = 0; i < 20 && !(a_if_gnt || a_d_gnt); i++) tick();
            chk("ctn_gnt_seen", a_if_gnt | a_d_gnt, 1);
            chk("ctn_owner", a_d_gnt, exp_d);
            for (i = 0; i < 20 && !(exp_d ? a_d_done : a_if_done); i++) tick();
            chk("ctn_done_seen", exp_d ? a_d_done : a_if_done, 1);
            chk("ctn_rdata", exp_d ? a_d_rdata : a_if_rdata,
                exp_d ? 32'hCAFEF00D : 32'hDEADBEEF);
            if (exp_d) a_d_req = 0; else a_if_req = 0;
            tick();
            if (k < 2) begin
                if (exp_d) a_d_req = 1; else a_if_req = 1;
            end
            exp_d = ~exp_d;
        end
        tick(); tick();

        // Fetch latency: gnt cycle 1, done cycle 4.
        a_if_addr = 32'h40; a_if_req = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("fetch_gnt", a_if_gnt, (c == 1));
            chk("fetch_done", a_if_done, (c == 4));
            chk("fetch_no_wr", a_mem_wr, 0);
            if (c == 4) begin
                chk("fetch_rdata", a_if_rdata, 32'hDEADBEEF);
                a_if_req = 0;
            end
        end

        // Byte store RMW into lane 2.
        a_d_we = 1; a_d_size = 2'b10; a_d_addr = 32'h102; a_d_wdata = 32'hAB; a_d_req = 1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("bst_gnt", a_d_gnt, (c == 1));
            chk("bst_wr", a_mem_wr, (c == 4));
            chk("bst_done", a_d_done, (c == 5));
            if (c == 4) begin
                chk("bst_wdata", a_mem_wdata, 32'h11AB3344);
                chk("bst_waddr", a_mem_addr, 32'h100);
            end
            if (c == 5) begin
                chk("bst_err", a_d_err, 0);
                a_d_req = 0;
            end
        end
        chk("bst_mem", mem_a[8'h40], 32'h11AB3344);

        // Misaligned halfword store: gnt and done together, error, no write.
        a_d_size = 2'b01; a_d_addr = 32'h101; a_d_wdata = 32'h1234; a_d_req = 1;
        tick();
        chk("mis_gnt", a_d_gnt, 1);
        chk("mis_done", a_d_done, 1);
        chk("mis_err", a_d_err, 1);
        chk("mis_wr", a_mem_wr, 0);
        a_d_req = 0;
        tick();
        chk("mis_idle", a_busy, 0);
        chk("mis_wr2", a_mem_wr, 0);
        chk("mis_mem", mem_a[8'h40], 32'h11AB3344);

        // Aligned word store clears a stale d_err.
        a_d_size = 2'b00; a_d_addr = 32'h300; a_d_wdata = 32'h0BADF00D; a_d_req = 1;
        tick();
        chk("wst_wr", a_mem_wr, 1);
        chk("wst_wdata", a_mem_wdata, 32'h0BADF00D);
        tick();
        chk("wst_done", a_d_done, 1);
        chk("wst_err_clr", a_d_err, 0);
        a_d_req = 0;
        tick();
        chk("wst_mem", mem_a[8'hC0], 32'h0BADF00D);

        // Reset while in RMW_RD of a halfword store.
        a_d_size = 2'b01; a_d_addr = 32'h200; a_d_wdata = 32'h9999; a_d_req = 1;
        tick();
        chk("rrst_gnt", a_d_gnt, 1);
        tick();
        chk("rrst_busy_before", a_busy, 1);
        chk("rrst_wr_before", a_mem_wr, 0);
        reset = 1; a_d_req = 0;
        tick();
        reset = 0;
        chk("rrst_busy_after", a_busy, 0);
        chk("rrst_done_after", a_d_done, 0);
        chk("rrst_wr_after", a_mem_wr, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rrst_quiet", {a_mem_wr, a_d_done, a_busy}, 0);
        end
        chk("rrst_mem", mem_a[8'h80], 32'h55667788);
        a_if_addr = 32'h40; a_if_req = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("rrst_fetch_done", a_if_done, (c == 4));
        end
        chk("rrst_fetch_rdata", a_if_rdata, 32'hDEADBEEF);
        a_if_req = 0;
        tick();

        // READ_LAT=1 instance: load done cycle 3, d_rdata held through a fetch.
        b_d_addr = 32'h8; b_d_req = 1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("l1_gnt", b_d_gnt, (c == 1));
            chk("l1_done", b_d_done, (c == 3));
        end
        chk("l1_rdata", b_d_rdata, 32'hCAFEF00D);
        b_d_req = 0;
        tick();
        b_if_addr = 32'h40; b_if_req = 1;
        for (i = 0; i < 20 && !b_if_done; i++) tick();
        chk("l1_if_done_seen", b_if_done, 1);
        chk("l1_if_rdata", b_if_rdata, 32'hDEADBEEF);
        chk("l1_d_rdata_held", b_d_rdata, 32'hCAFEF00D);
        b_if_req = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
